// File: rtl/spi_reader_arb.sv
// spi_reader_arb: round-robin arbiter sharing one spi_flash_reader between
// N_REQ consumers. Each consumer owns an addr/len/go/rdy command slot; the
// reader's byte stream is steered back to whichever consumer was granted.
module spi_reader_arb #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ-1:0]        req_go,
    output logic [N_REQ-1:0]        req_rdy,
    output logic [7:0]              req_data,
    output logic [N_REQ-1:0]        req_valid,
    output logic [ADDR_W-1:0]       sr_addr,
    output logic [LEN_W-1:0]        sr_len,
    output logic                    sr_go,
    input  logic                    sr_rdy,
    input  logic [7:0]              sr_data,
    input  logic                    sr_valid
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [GW-1:0]     r_grant;
    logic [GW-1:0]     w_grant_next;
    logic [GW-1:0]     r_last;
    logic [GW-1:0]     w_pick;
    logic              w_pick_vld;
    int                w_idx;
    logic [1:0]        r_busy_cnt;
    logic [1:0]        w_busy_cnt_next;
    logic              w_done;
    logic              w_launch;
    logic              w_stream;

    logic [N_REQ-1:0]  r_pend;
    logic [N_REQ-1:0]  w_pend_next;
    logic [N_REQ-1:0]  w_acc;
    logic [N_REQ-1:0]  w_clr;
    logic [N_REQ-1:0]  r_rdy;

    logic [ADDR_W-1:0] r_slot_addr [N_REQ];
    logic [LEN_W-1:0]  r_slot_len  [N_REQ];

    logic [ADDR_W-1:0] r_sr_addr;
    logic [LEN_W-1:0]  r_sr_len;
    logic              r_sr_go;

    // The reader's stream belongs to the current grant while it is running.
    assign w_stream = (r_state == S_BUSY) || (r_state == S_DRAIN);

    // Per-requester accept/clear terms and data-strobe steering.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_acc[gi]       = req_go[gi] & r_rdy[gi];
            assign w_clr[gi]       = w_done && (r_grant == GW'(gi));
            assign w_pend_next[gi] = (r_pend[gi] | w_acc[gi]) & ~w_clr[gi];
            assign req_valid[gi]   = sr_valid & w_stream & (r_grant == GW'(gi));
        end
    endgenerate

    assign req_data = sr_data;
    assign req_rdy  = r_rdy;
    assign sr_addr  = r_sr_addr;
    assign sr_len   = r_sr_len;
    assign sr_go    = r_sr_go;

    // Round-robin search: first pending slot after the last one served.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(r_last) + k) % N_REQ;
            if (!w_pick_vld && r_pend[w_idx]) begin
                w_pick_vld = 1'b1;
                w_pick     = GW'(w_idx);
            end
        end
    end

    // Next-state logic: arbitrate, launch one command, wait for the reader.
    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_busy_cnt_next = r_busy_cnt;
        w_done          = 1'b0;
        w_launch        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld && sr_rdy) begin
                    w_grant_next = w_pick;
                    w_launch     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_busy_cnt_next = 2'd0;
                w_state_next    = S_BUSY;
            end
            S_BUSY: begin
                // A reader that never drops rdy is treated as a zero-length job.
                if (!sr_rdy || (r_busy_cnt == 2'd3)) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_busy_cnt_next = r_busy_cnt + 2'd1;
                end
            end
            S_DRAIN: begin
                if (sr_rdy) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM state, grant bookkeeping and pending/ready flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_last     <= GW'(N_REQ - 1);
            r_busy_cnt <= 2'd0;
            r_pend     <= '0;
            r_rdy      <= '1;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_busy_cnt <= w_busy_cnt_next;
            r_pend     <= w_pend_next;
            r_rdy      <= ~w_pend_next;
            if (r_state == S_ISSUE) begin
                r_last <= r_grant;
            end
        end
    end

    // Command slots: captured on accept, stable while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                r_slot_addr[k] <= '0;
                r_slot_len[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (w_acc[k]) begin
                    r_slot_addr[k] <= req_addr[k*ADDR_W +: ADDR_W];
                    r_slot_len[k]  <= req_len[k*LEN_W +: LEN_W];
                end
            end
        end
    end

    // Reader command outputs: loaded only when launching, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_addr <= '0;
            r_sr_len  <= '0;
            r_sr_go   <= 1'b0;
        end else begin
            r_sr_go <= w_launch;
            if (w_launch) begin
                r_sr_addr <= r_slot_addr[w_pick];
                r_sr_len  <= r_slot_len[w_pick];
            end
        end
    end

endmodule

// File: tb/tb_spi_reader_arb.sv
// Bench for spi_reader_arb: a transaction-level arbitration model plus a
// behavioural flash-reader model, driven by directed tables and random traffic.
module tb_spi_reader_arb;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_len = '0;
    logic [N-1:0]    req_go = '0;
    logic [N-1:0]    req_rdy;
    logic [7:0]      req_data;
    logic [N-1:0]    req_valid;
    logic [AW-1:0]   sr_addr;
    logic [LW-1:0]   sr_len;
    logic            sr_go;
    logic            sr_rdy = 1'b1;
    logic [7:0]      sr_data = '0;
    logic            sr_valid = 1'b0;

    always #5 clk = ~clk;

    spi_reader_arb #(.N_REQ(N), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_len(req_len), .req_go(req_go),
        .req_rdy(req_rdy), .req_data(req_data), .req_valid(req_valid),
        .sr_addr(sr_addr), .sr_len(sr_len), .sr_go(sr_go),
        .sr_rdy(sr_rdy), .sr_data(sr_data), .sr_valid(sr_valid)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit            pend_m [N];
    int            drv_m  [N];
    logic [AW-1:0] caddr_m[N];
    logic [LW-1:0] clen_m [N];
    bit            rdy_m  [N];
    bit            rdy_nx [N];
    int            last_m;
    bit            inflight;
    int            gcur, gstart, beats;
    bit            noop;
    bit            stray_en;
    int            idle_from;
    logic [AW-1:0] hold_addr;
    logic [LW-1:0] hold_len;
    bit            want_go  [N];
    logic [AW-1:0] want_addr[N];
    logic [LW-1:0] want_len [N];
    int            go_log[$];
    int            obs_cnt[N];

    typedef struct {
        logic [N-1:0] mask;
        int           n_exp;
        int           exp_order[3];
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < N; i++) r |= pend_m[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            pend_m[i] = 0; rdy_m[i] = 1; want_go[i] = 0; obs_cnt[i] = 0;
        end
        last_m = N - 1; inflight = 0; beats = 0; noop = 0;
        hold_addr = '0; hold_len = '0; gcur = 0; gstart = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_go = '0; sr_rdy = 1'b1; sr_valid = 1'b0; sr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_from = cyc;
    endtask

    task automatic complete();
        pend_m[gcur] = 0;
        rdy_nx[gcur] = 1;
        inflight = 0;
        idle_from = cyc + 1;
    endtask

    // One clock of checking, reader modelling and request driving.
    task automatic step();
        int  eg;
        bit  eg_vld;
        bit  beat;
        int  idx;
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("req_rdy[%0d]", i), req_rdy[i], rdy_m[i]);
        // Which grant, if any, the round-robin rule launches now
        eg_vld = 0; eg = 0; beat = 0;
        if (!inflight && cyc >= idle_from + 1) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last_m + k) % N;
                if (!eg_vld && pend_m[idx] && drv_m[idx] <= cyc - 2) begin
                    eg_vld = 1; eg = idx;
                end
            end
        end
        chk("sr_go", sr_go, eg_vld);
        for (int i = 0; i < N; i++) rdy_nx[i] = rdy_m[i];
        sr_valid = 1'b0;
        if (sr_go) begin
            go_log.push_back(int'(sr_addr[23:20]));
            if (eg_vld) begin
                chk("sr_addr", sr_addr, caddr_m[eg]);
                chk("sr_len", sr_len, clen_m[eg]);
                gcur = eg; hold_addr = caddr_m[eg]; hold_len = clen_m[eg];
            end else begin
                gcur = int'(sr_addr[23:20]) % N; hold_addr = sr_addr; hold_len = sr_len;
            end
            last_m = gcur; inflight = 1; gstart = cyc;
            if (!noop) begin
                sr_rdy = 1'b0;
                beats = eg_vld ? int'(clen_m[eg]) : int'(sr_len);
            end
        end else begin
            chk("sr_addr_hold", sr_addr, hold_addr);
            chk("sr_len_hold", sr_len, hold_len);
            if (inflight) begin
                if (noop) begin
                    if (cyc == gstart + 5) complete();
                end else if (beats > 0) begin
                    if ($urandom_range(3) != 0) begin
                        sr_valid = 1'b1; sr_data = 8'($urandom); beats--; beat = 1;
                    end
                end else if (cyc >= gstart + 2) begin
                    sr_rdy = 1'b1;
                    complete();
                end
            end else if (stray_en && cyc >= idle_from && $urandom_range(3) == 0) begin
                sr_valid = 1'b1; sr_data = 8'($urandom);
            end
        end
        for (int i = 0; i < N; i++) begin
            req_go[i] = 1'b0;
            if (want_go[i]) begin
                req_go[i] = 1'b1;
                req_addr[i*AW +: AW] = want_addr[i];
                req_len[i*LW +: LW]  = want_len[i];
                if (rdy_m[i]) begin
                    pend_m[i] = 1; drv_m[i] = cyc;
                    caddr_m[i] = want_addr[i]; clen_m[i] = want_len[i];
                    rdy_nx[i] = 0;
                end
                want_go[i] = 0;
            end
        end
        for (int i = 0; i < N; i++) rdy_m[i] = rdy_nx[i];
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("req_valid[%0d]", i), req_valid[i], beat && (gcur == i));
            if (req_valid[i]) obs_cnt[i]++;
        end
        if (beat) chk("req_data", req_data, sr_data);
    endtask

    task automatic settle(input string name);
        int n = 0;
        while ((inflight || any_pend()) && n < 2000) begin
            step(); n++;
        end
        chk({name, "_timeout"}, (n >= 2000), 0);
        step(); step();
    endtask

    task automatic ask(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        want_go[i] = 1; want_addr[i] = a; want_len[i] = l;
    endtask

    initial begin
        vec_t tbl[7];
        int   n, t_go;

        // Grant order expected for each go pattern, starting from reset
        tbl[0] = '{mask: 3'b011, n_exp: 2, exp_order: '{0, 1, 0}};
        tbl[1] = '{mask: 3'b001, n_exp: 1, exp_order: '{0, 0, 0}};
        tbl[2] = '{mask: 3'b111, n_exp: 3, exp_order: '{1, 2, 0}};
        tbl[3] = '{mask: 3'b110, n_exp: 2, exp_order: '{1, 2, 0}};
        tbl[4] = '{mask: 3'b101, n_exp: 2, exp_order: '{0, 2, 0}};
        tbl[5] = '{mask: 3'b100, n_exp: 1, exp_order: '{2, 0, 0}};
        tbl[6] = '{mask: 3'b010, n_exp: 1, exp_order: '{1, 0, 0}};

        stray_en = 1;
        do_reset();
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, {N{1'b1}});
        chk("rst_sr_go", sr_go, 0);
        chk("rst_sr_addr", sr_addr, 0);
        chk("rst_sr_len", sr_len, 0);
        chk("rst_req_valid", req_valid, 0);
        idle_from = cyc;

        // Directed table of simultaneous request patterns
        for (int v = 0; v < 7; v++) begin
            go_log.delete();
            for (int i = 0; i < N; i++)
                if (tbl[v].mask[i]) ask(i, {4'(i), 4'(v), 16'h0A00 + 16'(i)}, 16'(2 + i));
            step();
            settle($sformatf("tbl%0d", v));
            chk($sformatf("tbl%0d_count", v), go_log.size(), tbl[v].n_exp);
            for (int k = 0; k < tbl[v].n_exp && k < go_log.size(); k++)
                chk($sformatf("tbl%0d_grant%0d", v, k), go_log[k], tbl[v].exp_order[k]);
        end

        // Single 256-byte read on requester 0
        for (int i = 0; i < N; i++) obs_cnt[i] = 0;
        ask(0, 24'h040000, 16'h0100);
        step();
        settle("single");
        chk("single_beats0", obs_cnt[0], 256);
        chk("single_beats1", obs_cnt[1], 0);
        chk("single_beats2", obs_cnt[2], 0);

        // Fairness: both requesters re-issue as soon as they are ready
        do_reset();
        go_log.delete();
        ask(0, 24'h050000, 16'd4);
        ask(1, 24'h150000, 16'd4);
        n = 0;
        while (go_log.size() < 4 && n < 3000) begin
            step(); n++;
            if (go_log.size() < 4)
                for (int i = 0; i < 2; i++)
                    if (rdy_m[i]) ask(i, {4'(i), 20'h50000}, 16'd4);
        end
        chk("fair_timeout", (n >= 3000), 0);
        for (int k = 0; k < 4 && k < go_log.size(); k++)
            chk($sformatf("fair_grant%0d", k), go_log[k], k % 2);
        settle("fair");

        // Busy ignore: go pulses while not ready must not be captured
        go_log.delete();
        ask(0, 24'h040000, 16'd8);
        step();
        for (int k = 0; k < 4; k++) begin
            ask(0, 24'h123456, 16'd3);
            step();
        end
        settle("busy_ignore");
        chk("busy_ignore_gos", go_log.size(), 1);
        chk("busy_ignore_addr", sr_addr, 24'h040000);

        // Reader never drops rdy: arbiter times out of BUSY and completes
        stray_en = 0; noop = 1;
        ask(1, 24'h1ABCDE, 16'd5);
        step();
        n = 0;
        while (!sr_go && n < 50) begin step(); n++; end
        t_go = cyc;
        n = 0;
        while (!req_rdy[1] && n < 50) begin step(); n++; end
        chk("noop_rdy_latency", cyc - t_go, 6);
        settle("noop");
        noop = 0; stray_en = 1;

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < N; i++) obs_cnt[i] = 0;
        ask(0, 24'h040000, 16'h0100);
        n = 0;
        while (obs_cnt[0] < 10 && n < 500) begin step(); n++; end
        chk("rst_mid_timeout", (n >= 500), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_sr_go", sr_go, 0);
        chk("rst_mid_req_valid", req_valid, 0);
        chk("rst_mid_req_rdy", req_rdy, {N{1'b1}});
        do_reset();
        go_log.delete();
        ask(1, 24'h160000, 16'd3);
        ask(0, 24'h060000, 16'd3);
        step();
        settle("post_rst");
        chk("post_rst_count", go_log.size(), 2);
        if (go_log.size() > 0) chk("post_rst_first", go_log[0], 0);

        // Random traffic against the model
        for (int s = 0; s < 3000; s++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(99) < 20)
                    ask(i, {4'(i), 20'($urandom)}, 16'($urandom_range(6)));
            step();
        end
        settle("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
